exec_unit: RTL
==============

// Module: exec_unit
// PURPOSE
//   Execute stage between register-file read and write-back. Accepts an op plus
//   two operands (register-file data1/data2) and a destination address.
//   Produces a registered write-back (wb_en/wb_addr/wb_data) that drives
//   register_file write_en/regw/dataw.
//   Single-cycle ops take 1 cycle. MUL uses an iterative shift-add FSM.
// PARAMETERS
//   DATA_WIDTH      8   operand/result width; power of two, >= 4
//   REG_ADDR_WIDTH  4   destination register address width
// PORTS
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous reset, active-high
//   in_valid   in   1               op/a/b/dest valid this cycle
//   in_ready   out  1               unit can accept (state==IDLE)
//   op         in   4               opcode (see BEHAVIOUR)
//   a          in   DATA_WIDTH      operand A (data1)
//   b          in   DATA_WIDTH      operand B (data2)
//   dest       in   REG_ADDR_WIDTH  destination register
//   wb_en      out  1               1-cycle write-back strobe
//   wb_addr    out  REG_ADDR_WIDTH  write-back register
//   wb_data    out  DATA_WIDTH      write-back value
//   flag_z     out  1               result==0 of last write-back
//   flag_c     out  1               carry/borrow of last ADD/SUB
//   err        out  1               1-cycle pulse: illegal opcode accepted
// BEHAVIOUR
//   - Reset: state=IDLE; wb_en=0, wb_addr=0, wb_data=0, flag_z=0, flag_c=0, err=0.
//     in_ready=1 once rst deasserts.
//   - Accept = in_valid & in_ready, sampled at a rising edge N.
//     in_ready is combinational: (state==IDLE).
//   - Opcodes:
//     0 ADD  a+b, C=carry-out
//     1 SUB  a-b, C=borrow (a<b unsigned)
//     2 AND
//     3 OR
//     4 XOR
//     5 SHL  a<<b[log2(DW)-1:0]
//     6 SHR  logical a>>b[log2(DW)-1:0]
//     7 MUL  low DW bits of a*b unsigned
//     8 MOV  b
//     9-15   illegal: err=1 for one cycle after edge N, no write-back,
//            flags unchanged.
//   - Single-cycle ops (0-6, 8): after edge N, wb_en=1, wb_data, wb_addr=dest
//     for exactly one cycle. Back-to-back accepts give a wb_en pulse every cycle.
//   - flag_z updates on every write-back. flag_c updates only on ADD/SUB;
//     other ops hold it.
//   - FSM states: IDLE, MUL.
//     IDLE -> MUL on accept of op 7: latch a, b, dest; acc=0; cnt=0.
//     MUL, each edge: if b_sh[0], acc+=a_sh; a_sh<<=1; b_sh>>=1; cnt++.
//     After DATA_WIDTH MUL cycles (edge N+DW), return to IDLE and write back:
//     wb_en=1 for the cycle after edge N+DW.
//     in_ready=0 during MUL. in_valid is ignored during MUL; upstream must hold.
//   - The MUL write-back cycle has in_ready=1, so a new op may be accepted at
//     edge N+DW+1.
//   - All arithmetic is modulo 2^DATA_WIDTH. Overflow bits are discarded
//     except ADD carry.
//   - Reset mid-MUL: abort immediately, no write-back, flags cleared.
//   - Outputs are registered. wb_data/wb_addr hold their last value when
//     wb_en=0.
// TESTING
//   - Reset -> all outputs 0, in_ready=1. Assert rst during a MUL (cnt=3)
//     -> wb_en never pulses, state IDLE.
//   - ADD a=0xF0 b=0x20 dest=3 -> next cycle wb_en=1, wb_addr=3,
//     wb_data=0x10, flag_c=1, flag_z=0.
//   - SUB a=0x05 b=0x05 then SUB a=0x01 b=0x02 on consecutive cycles
//     -> wb_data=0x00 (Z=1, C=0), then 0xFF (Z=0, C=1).
//     Two consecutive wb_en pulses.
//   - MUL a=13 b=11 dest=7 (DW=8) -> in_ready low 8 cycles;
//     wb_data=0x8F, wb_addr=7 on cycle 9. MUL 0xFF*0xFF -> 0x01.
//   - SHL a=0x81 b=0x09 -> 0x02 (shift amount 1).
//     SHR a=0x80 b=0x07 -> 0x01. AND/OR/XOR/MOV vs. reference model.
//   - op=12 -> err pulse 1 cycle, wb_en=0, flag_c/flag_z unchanged.
//     in_valid held during MUL -> no extra accept.

Source files
------------

// File: rtl/exec_unit.sv
// exec_unit: execute stage that turns op/a/b/dest into a registered write-back
//   clk, rst               clock, asynchronous active-high reset
//   in_valid, in_ready     accept handshake (in_ready high only in IDLE)
//   op, a, b, dest         opcode, operands, destination register
//   wb_en, wb_addr, wb_data  one-cycle write-back strobe, address, value
//   flag_z, flag_c         zero of last write-back, carry/borrow of last ADD/SUB
//   err                    one-cycle pulse when an illegal opcode is accepted
module exec_unit #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                op,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  input  logic [REG_ADDR_WIDTH-1:0] dest,
  output logic                      wb_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic                      err
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam logic [SW-1:0] CNT_LAST = SW'(DATA_WIDTH - 1);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7,
                         OP_MOV = 4'd8;
  logic [0:0]                r_state;
  logic [DATA_WIDTH-1:0]     r_a_sh, r_b_sh, r_acc;
  logic [SW-1:0]             r_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_dest;
  logic                      w_accept, w_legal, w_carry_op;
  logic [DATA_WIDTH:0]       w_sum, w_diff;
  logic [DATA_WIDTH-1:0]     w_res, w_acc_next;
  logic [SW-1:0]             w_sh;
  assign in_ready   = (r_state == S_IDLE);
  assign w_accept   = in_valid & in_ready;
  assign w_legal    = (op <= OP_MOV);
  assign w_carry_op = (op == OP_ADD) || (op == OP_SUB);
  assign w_sh       = b[SW-1:0];
  // Extra top bit of the sum is the carry; of the difference it is the borrow (a<b).
  assign w_sum      = {1'b0, a} + {1'b0, b};
  assign w_diff     = {1'b0, a} - {1'b0, b};
  assign w_acc_next = r_acc + (r_b_sh[0] ? r_a_sh : '0);
  always_comb begin
    w_res = '0;
    case (op)
      OP_ADD:  w_res = w_sum[DATA_WIDTH-1:0];
      OP_SUB:  w_res = w_diff[DATA_WIDTH-1:0];
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_SHL:  w_res = a << w_sh;
      OP_SHR:  w_res = a >> w_sh;
      OP_MOV:  w_res = b;
      default: w_res = '0;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dest  <= '0;
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      err     <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      err   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          if (!w_legal) begin
            err <= 1'b1;
          end else if (op == OP_MUL) begin
            r_state <= S_MUL;
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_dest  <= dest;
            r_acc   <= '0;
            r_cnt   <= '0;
          end else begin
            wb_en   <= 1'b1;
            wb_addr <= dest;
            wb_data <= w_res;
            flag_z  <= (w_res == '0);
            if (w_carry_op) flag_c <= (op == OP_ADD) ? w_sum[DATA_WIDTH] : w_diff[DATA_WIDTH];
          end
        end
      end else begin
        r_acc  <= w_acc_next;
        r_a_sh <= r_a_sh << 1;
        r_b_sh <= r_b_sh >> 1;
        r_cnt  <= r_cnt + SW'(1);
        // Last shift-add step writes the final partial sum straight to the port.
        if (r_cnt == CNT_LAST) begin
          r_state <= S_IDLE;
          wb_en   <= 1'b1;
          wb_addr <= r_dest;
          wb_data <= w_acc_next;
          flag_z  <= (w_acc_next == '0);
        end
      end
    end
  end
endmodule
